// File: rtl/fifo_rd_stream.sv
// Read-side adapter for a standard-mode sync FIFO: prefetches into a 3-entry
// buffer to hide the 1-cycle DOUT latency and presents a valid/ready stream.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int PKT_BEATS = 0,
  parameter int BCNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  output logic              FIFO_RD_EN,
  input  logic [WIDTH-1:0]  FIFO_DOUT,
  input  logic              FIFO_EMPTY,
  output logic              M_VALID,
  output logic [WIDTH-1:0]  M_DATA,
  output logic              M_LAST,
  input  logic              M_READY,
  output logic [1:0]        OCC,
  output logic [BCNT_W-1:0] BEAT_CNT
);

  localparam int PW    = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int LASTI = (PKT_BEATS > 0) ? PKT_BEATS - 1 : 0;

  logic [2:0][WIDTH-1:0] mem_q, mem_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, occ_q, occ_d;
  logic                  inflight_q, inflight_d, drop_q, drop_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [PW-1:0]         pkt_q, pkt_d;
  logic                  rd_en, capture, pop, m_valid, pkt_end;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue decision only looks at registered occupancy, so M_READY never
  // reaches FIFO_RD_EN combinationally; RST gating keeps the strobe low in reset.
  assign rd_en   = RST && !FIFO_EMPTY && !FLUSH &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
  assign m_valid = (occ_q != 2'd0);
  assign capture = inflight_q && !drop_q && !FLUSH;
  assign pop     = m_valid && M_READY && !FLUSH;
  assign pkt_end = (pkt_q == PW'(LASTI));

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    bcnt_d     = bcnt_q;
    pkt_d      = pkt_q;
    drop_d     = 1'b0;
    inflight_d = rd_en;
    if (FLUSH) begin
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      occ_d    = 2'd0;
      bcnt_d   = '0;
      pkt_d    = '0;
      drop_d   = inflight_q;
    end else begin
      if (capture) begin
        mem_d[wr_ptr_q] = FIFO_DOUT;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        bcnt_d   = bcnt_q + BCNT_W'(1);
        pkt_d    = pkt_end ? '0 : pkt_q + PW'(1);
      end
      case ({capture, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_q      <= '0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      bcnt_q     <= '0;
      pkt_q      <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      bcnt_q     <= bcnt_d;
      pkt_q      <= pkt_d;
    end
  end

  assign FIFO_RD_EN = rd_en;
  assign M_VALID    = m_valid;
  assign M_DATA     = mem_q[rd_ptr_q];
  assign M_LAST     = (PKT_BEATS > 0) && m_valid && pkt_end;
  assign OCC        = occ_q;
  assign BEAT_CNT   = bcnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a behavioural standard-mode FIFO feeds the DUT; stimulus
// queues expected words, a negedge monitor checks every accepted beat.
module tb_fifo_rd_stream;
  localparam int W = 8;
  localparam int PB = 4;
  localparam int BW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          FLUSH = 1'b0;
  logic          FIFO_RD_EN;
  logic [W-1:0]  FIFO_DOUT = '0;
  logic          FIFO_EMPTY;
  logic          M_VALID;
  logic [W-1:0]  M_DATA;
  logic          M_LAST;
  logic          M_READY = 1'b0;
  logic [1:0]    OCC;
  logic [BW-1:0] BEAT_CNT;

  fifo_rd_stream #(.WIDTH(W), .PKT_BEATS(PB), .BCNT_W(BW)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .FIFO_RD_EN(FIFO_RD_EN),
    .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY), .M_VALID(M_VALID),
    .M_DATA(M_DATA), .M_LAST(M_LAST), .M_READY(M_READY), .OCC(OCC),
    .BEAT_CNT(BEAT_CNT)
  );

  always #5 CLK = ~CLK;

  int nchk = 0, nfail = 0;
  int n_acc = 0, n_last = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Upstream FIFO model: DOUT registered one cycle after RD_EN
  logic [W-1:0] fmem [1024];
  int rd_idx = 0, wr_idx = 0;
  assign FIFO_EMPTY = (rd_idx == wr_idx);
  always @(posedge CLK) begin
    check("rd_en_while_empty", 32'(FIFO_RD_EN && FIFO_EMPTY), 32'd0);
    if (FIFO_RD_EN) begin
      FIFO_DOUT <= fmem[rd_idx[9:0]];
      rd_idx    <= rd_idx + 1;
    end
  end

  logic [W-1:0] sb [$];
  int sb_base = 0;
  int exp_pkt = 0;
  logic [BW-1:0] exp_cnt = '0;
  logic hold_q = 1'b0;
  logic [W-1:0] hold_data = '0;
  logic hold_last = 1'b0;

  task automatic push(input logic [W-1:0] d);
    fmem[wr_idx[9:0]] = d;
    wr_idx = wr_idx + 1;
    sb.push_back(d);
  endtask

  // Words already pulled out of the FIFO are lost on flush/reset
  task automatic discard();
    while (sb_base < rd_idx && sb.size() > 0) begin
      void'(sb.pop_front());
      sb_base++;
    end
    exp_pkt = 0;
    exp_cnt = '0;
    hold_q  = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      check("beat_cnt", 32'(BEAT_CNT), 32'(exp_cnt));
      if (hold_q) begin
        check("hold_valid", 32'(M_VALID), 32'd1);
        check("hold_data", 32'(M_DATA), 32'(hold_data));
        check("hold_last", 32'(M_LAST), 32'(hold_last));
      end
      if (FLUSH) discard();
      else if (M_VALID && M_READY) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("data", 32'(M_DATA), 32'(sb[0]));
          check("last", 32'(M_LAST), 32'(exp_pkt == PB - 1));
          void'(sb.pop_front());
          sb_base++;
          if (M_LAST) n_last++;
          exp_pkt = (exp_pkt + 1) % PB;
          exp_cnt = exp_cnt + BW'(1);
          n_acc++;
        end
      end
      hold_q    = M_VALID && !M_READY && !FLUSH;
      hold_data = M_DATA;
      hold_last = M_LAST;
    end else hold_q = 1'b0;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int maxc, input bit rnd);
    int c = 0;
    while ((sb.size() != 0 || M_VALID) && c < maxc) begin
      M_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      c++;
    end
    check("drain_in_budget", 32'(c < maxc), 32'd1);
    M_READY = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int a0, l0;
    #2;
    check("rst_valid", 32'(M_VALID), 32'd0);
    check("rst_occ", 32'(OCC), 32'd0);
    check("rst_rden", 32'(FIFO_RD_EN), 32'd0);
    check("rst_data", 32'(M_DATA), 32'd0);
    check("rst_last", 32'(M_LAST), 32'd0);
    check("rst_cnt", 32'(BEAT_CNT), 32'd0);
    tick(); tick();
    RST = 1'b1;
    tick();

    // Streaming, latency 2 clks, 8 consecutive beats
    a0 = n_acc;
    M_READY = 1'b1;
    for (int i = 1; i <= 8; i++) push(W'(i));
    tick();
    check("lat_valid_c1", 32'(M_VALID), 32'd0);
    tick();
    check("lat_valid_c2", 32'(M_VALID), 32'd1);
    check("first_data", 32'(M_DATA), 32'h01);
    repeat (8) tick();
    check("stream_beats", 32'(n_acc - a0), 32'd8);
    check("stream_cnt", 32'(BEAT_CNT), 32'd8);
    check("stream_idle", 32'(M_VALID), 32'd0);
    M_READY = 1'b0;
    tick();

    // Backpressure: occupancy saturates at 3 and reads stop
    for (int i = 0; i < 6; i++) push(W'(i));
    repeat (10) tick();
    check("bp_occ", 32'(OCC), 32'd3);
    check("bp_rden", 32'(FIFO_RD_EN), 32'd0);
    check("bp_reads", 32'(rd_idx - (wr_idx - 6)), 32'd3);
    drain(100, 1'b0);

    // Random ready over 250 words (BEAT_CNT wraps past 255)
    for (int i = 0; i < 250; i++) push(W'(i * 7 + 3));
    drain(3000, 1'b1);
    check("rand_all_out", 32'(sb.size()), 32'd0);

    // Flush with OCC=2 and a read in flight
    for (int i = 0; i < 5; i++) push(W'(8'hA0 + i));
    repeat (3) tick();
    check("fl_pre_occ", 32'(OCC), 32'd2);
    check("fl_pre_rden", 32'(FIFO_RD_EN), 32'd0);
    FLUSH = 1'b1;
    check("fl_rden_forced", 32'(FIFO_RD_EN), 32'd0);
    tick();
    FLUSH = 1'b0;
    check("fl_occ", 32'(OCC), 32'd0);
    check("fl_valid", 32'(M_VALID), 32'd0);
    check("fl_cnt", 32'(BEAT_CNT), 32'd0);
    M_READY = 1'b1;
    repeat (2) tick();
    check("fl_next_word", 32'(M_DATA), 32'hA3);
    drain(100, 1'b0);

    // Packets of 4 with toggling ready: LAST on beats 4, 8, 12
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    l0 = n_last;
    for (int i = 0; i < 12; i++) push(W'(8'h40 + i));
    for (int c = 0; c < 200 && (sb.size() != 0 || M_VALID); c++) begin
      M_READY = ~M_READY;
      tick();
    end
    check("pkt_lasts", 32'(n_last - l0), 32'd3);
    check("pkt_cnt", 32'(BEAT_CNT), 32'd12);
    M_READY = 1'b0;
    repeat (3) tick();

    // Async reset mid-stream
    M_READY = 1'b1;
    for (int i = 0; i < 10; i++) push(W'(8'hC0 + i));
    repeat (4) tick();
    #2;
    RST = 1'b0;
    discard();
    #1;
    check("ar_valid", 32'(M_VALID), 32'd0);
    check("ar_occ", 32'(OCC), 32'd0);
    check("ar_cnt", 32'(BEAT_CNT), 32'd0);
    check("ar_data", 32'(M_DATA), 32'd0);
    check("ar_last", 32'(M_LAST), 32'd0);
    check("ar_rden", 32'(FIFO_RD_EN), 32'd0);
    repeat (2) begin
      tick();
      check("ar_rden_held", 32'(FIFO_RD_EN), 32'd0);
    end
    RST = 1'b1;
    #1;
    check("ar_rden_release", 32'(FIFO_RD_EN), 32'd1);
    drain(100, 1'b0);
    check("ar_all_out", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
